// File: rtl/dii_packet_fifo_if.sv
// DII flit link: one direction of a valid/ready flit stream.
//   data  : flit payload (WIDTH bits)
//   first : first-flit marker
//   last  : last-flit marker
//   valid : producer has a flit
//   ready : consumer takes the flit this cycle
// master drives the flit, slave returns ready.
interface dii_packet_fifo_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] data;
  logic             first;
  logic             last;
  logic             valid;
  logic             ready;

  modport master (output data, output first, output last, output valid, input ready);
  modport slave  (input data, input first, input last, input valid, output ready);
endinterface

// File: rtl/dii_packet_fifo.sv
// Circular-buffer FIFO for DII flits with optional packet-atomic forwarding.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : synchronous discard of all stored flits
//   in_if      : flit input link (slave)
//   out_if     : flit output link (master), first-word fall-through
//   level      : stored flit count, 0..DEPTH
//   pkt_count  : stored last flits, 0..DEPTH
//   high_water : peak level since last rst/flush, only when
//                DII_PACKET_FIFO_WATERMARK_EN is defined
// FULLPACKET=1 holds output until a last flit is stored, or the FIFO is
// full, so a packet longer than DEPTH streams through instead of stalling.
module dii_packet_fifo #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned FULLPACKET = 0,
  parameter int unsigned LW         = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  dii_packet_fifo_if.slave        in_if,
  dii_packet_fifo_if.master       out_if,
  output logic [LW-1:0]           level,
  output logic [LW-1:0]           pkt_count
`ifdef DII_PACKET_FIFO_WATERMARK_EN
  ,
  output logic [LW-1:0]           high_water
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned EW = WIDTH + 2;

  // Entry layout: {first, last, data}
  logic [EW-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level_nxt;
  logic [LW-1:0] pkt_nxt;
  logic          full;
  logic          empty;
  logic          pkt_ok;
  logic          push;
  logic          pop;
  logic          head_last;

  // Status decode
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  // Packet gate; the full term lets oversized packets escape
  assign pkt_ok = (FULLPACKET == 0) || (pkt_count != '0) || full;

  // Handshake
  assign in_if.ready  = !rst && !flush && !full;
  assign out_if.valid = !empty && !flush && pkt_ok;
  assign push         = in_if.valid && in_if.ready;
  assign pop          = out_if.valid && out_if.ready;

  // Head flit straight from storage
  assign {out_if.first, out_if.last, out_if.data} = mem[rd_ptr];
  assign head_last = out_if.last;

  // Next occupancy and packet count
  always_comb begin
    level_nxt = level;
    pkt_nxt   = pkt_count;
    case ({push, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
    case ({push && in_if.last, pop && head_last})
      2'b10:   pkt_nxt = pkt_count + LW'(1);
      2'b01:   pkt_nxt = pkt_count - LW'(1);
      default: pkt_nxt = pkt_count;
    endcase
  end

  // Flit storage; not cleared by reset or flush
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_if.first, in_if.last, in_if.data};
    end
  end

  // Pointers and counters; rst takes priority over flush
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      pkt_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      level     <= level_nxt;
      pkt_count <= pkt_nxt;
    end
  end

`ifdef DII_PACKET_FIFO_WATERMARK_EN
  // Peak occupancy tracks the new level on the same edge
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      high_water <= '0;
    end else if (level_nxt > high_water) begin
      high_water <= level_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_dii_packet_fifo.sv
// Directed bench for dii_packet_fifo; four configurations share one stimulus
// bus and each phase checks the instance it targets.
module tb_dii_packet_fifo;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [7:0] in_data;
  logic       in_first;
  logic       in_last;
  logic       in_valid;
  logic       out_ready;

  int n_tests;
  int n_fail;

  // a: DEPTH4 stream, b: DEPTH8 packet, c: DEPTH4 packet, d: DEPTH5 stream
  dii_packet_fifo_if #(.WIDTH(8)) a_in ();
  dii_packet_fifo_if #(.WIDTH(8)) a_out ();
  dii_packet_fifo_if #(.WIDTH(8)) b_in ();
  dii_packet_fifo_if #(.WIDTH(8)) b_out ();
  dii_packet_fifo_if #(.WIDTH(8)) c_in ();
  dii_packet_fifo_if #(.WIDTH(8)) c_out ();
  dii_packet_fifo_if #(.WIDTH(8)) d_in ();
  dii_packet_fifo_if #(.WIDTH(8)) d_out ();

  logic [2:0] a_level, a_pkt;
  logic [3:0] b_level, b_pkt;
  logic [2:0] c_level, c_pkt;
  logic [2:0] d_level, d_pkt;
`ifdef DII_PACKET_FIFO_WATERMARK_EN
  logic [2:0] a_hw;
  logic [3:0] b_hw;
  logic [2:0] c_hw;
  logic [2:0] d_hw;
`endif

  assign a_in.data = in_data;  assign a_in.first = in_first;
  assign a_in.last = in_last;  assign a_in.valid = in_valid;
  assign a_out.ready = out_ready;
  assign b_in.data = in_data;  assign b_in.first = in_first;
  assign b_in.last = in_last;  assign b_in.valid = in_valid;
  assign b_out.ready = out_ready;
  assign c_in.data = in_data;  assign c_in.first = in_first;
  assign c_in.last = in_last;  assign c_in.valid = in_valid;
  assign c_out.ready = out_ready;
  assign d_in.data = in_data;  assign d_in.first = in_first;
  assign d_in.last = in_last;  assign d_in.valid = in_valid;
  assign d_out.ready = out_ready;

  dii_packet_fifo #(.WIDTH(8), .DEPTH(4), .FULLPACKET(0)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_if(a_in), .out_if(a_out),
    .level(a_level), .pkt_count(a_pkt)
`ifdef DII_PACKET_FIFO_WATERMARK_EN
    , .high_water(a_hw)
`endif
  );
  dii_packet_fifo #(.WIDTH(8), .DEPTH(8), .FULLPACKET(1)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_if(b_in), .out_if(b_out),
    .level(b_level), .pkt_count(b_pkt)
`ifdef DII_PACKET_FIFO_WATERMARK_EN
    , .high_water(b_hw)
`endif
  );
  dii_packet_fifo #(.WIDTH(8), .DEPTH(4), .FULLPACKET(1)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .in_if(c_in), .out_if(c_out),
    .level(c_level), .pkt_count(c_pkt)
`ifdef DII_PACKET_FIFO_WATERMARK_EN
    , .high_water(c_hw)
`endif
  );
  dii_packet_fifo #(.WIDTH(8), .DEPTH(5), .FULLPACKET(0)) u_d (
    .clk(clk), .rst(rst), .flush(flush), .in_if(d_in), .out_if(d_out),
    .level(d_level), .pkt_count(d_pkt)
`ifdef DII_PACKET_FIFO_WATERMARK_EN
    , .high_water(d_hw)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic flush_all();
    idle_in();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // Leaves a with level=3, pkt_count=1 (out_ready held low)
  task automatic fill3();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(32'h31 + 32'(i));
      in_first = (i != 1);
      in_last  = (i == 1);
      tick();
    end
    idle_in();
    #1;
    chk("fill_level", 32'(a_level), 32'd3);
    chk("fill_pkt", 32'(a_pkt), 32'd1);
  endtask

  task automatic chk_cleared(input string tag);
    #1;
    chk({tag, "_level"}, 32'(a_level), 32'd0);
    chk({tag, "_pkt"}, 32'(a_pkt), 32'd0);
    chk({tag, "_ovalid"}, 32'(a_out.valid), 32'd0);
    chk({tag, "_iready"}, 32'(a_in.ready), 32'd1);
  endtask

  int sent;
  int got;
  bit first_seen;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    idle_in();
    tick();
    tick();
    chk("rst_iready", 32'(a_in.ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_iready", 32'(a_in.ready), 32'd1);
    chk("post_rst_level", 32'(a_level), 32'd0);
    chk("post_rst_ovalid", 32'(a_out.valid), 32'd0);

    // DEPTH=4 stream: fill, then drain in order
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(32'hA1 + 32'(i));
      in_first = (i == 0);
      in_last  = (i == 3);
      #1;
      chk("a_fill_iready", 32'(a_in.ready), 32'd1);
      tick();
    end
    in_data = 8'hA5;
    #1;
    chk("a_full_iready", 32'(a_in.ready), 32'd0);
    chk("a_full_level", 32'(a_level), 32'd4);
    idle_in();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("a_drain_valid", 32'(a_out.valid), 32'd1);
      chk("a_drain_data", 32'(a_out.data), 32'hA1 + 32'(i));
      tick();
    end
    #1;
    chk("a_empty_level", 32'(a_level), 32'd0);
    chk("a_empty_valid", 32'(a_out.valid), 32'd0);
    flush_all();

    // DEPTH=8 packet mode: 3-flit packet held until its last flit lands
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(32'h10 + 32'(i));
      in_first = (i == 0);
      in_last  = (i == 2);
      #1;
      chk("b_hold_valid", 32'(b_out.valid), 32'd0);
      tick();
    end
    idle_in();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("b_drain_valid", 32'(b_out.valid), 32'd1);
      chk("b_drain_data", 32'(b_out.data), 32'h10 + 32'(i));
      chk("b_drain_pkt", 32'(b_pkt), 32'd1);
      tick();
    end
    #1;
    chk("b_end_pkt", 32'(b_pkt), 32'd0);
    chk("b_end_level", 32'(b_level), 32'd0);
    flush_all();

    // DEPTH=4 packet mode: 6-flit packet escapes through a full FIFO
    out_ready  = 1'b1;
    sent       = 0;
    got        = 0;
    first_seen = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      in_valid = (sent < 6);
      in_data  = 8'(32'h20 + 32'(sent));
      in_first = (sent == 0);
      in_last  = (sent == 5);
      #1;
      if (c_out.valid) begin
        if (!first_seen) begin
          first_seen = 1'b1;
          chk("c_escape_level", 32'(c_level), 32'd4);
          chk("c_escape_pkt", 32'(c_pkt), 32'd0);
        end
        chk("c_data", 32'(c_out.data), 32'h20 + 32'(got));
        got++;
      end
      if (in_valid && c_in.ready) sent++;
      tick();
    end
    idle_in();
    #1;
    chk("c_delivered", 32'(got), 32'd6);
    chk("c_end_level", 32'(c_level), 32'd0);
    chk("c_end_pkt", 32'(c_pkt), 32'd0);
    flush_all();

    // DEPTH=5 wrap: steady push/pop at level 2
    for (int i = 0; i < 12; i++) begin
      in_valid  = 1'b1;
      in_data   = 8'(i);
      in_first  = 1'b1;
      in_last   = 1'b1;
      out_ready = (i >= 2);
      #1;
      chk("d_level", 32'(d_level), (i < 2) ? 32'(i) : 32'd2);
      if (i >= 2) chk("d_data", 32'(d_out.data), 32'(i - 2));
      tick();
    end
    idle_in();
    for (int i = 10; i < 12; i++) begin
      #1;
      chk("d_tail_data", 32'(d_out.data), 32'(i));
      tick();
    end
    #1;
    chk("d_end_level", 32'(d_level), 32'd0);
    flush_all();

    // Flush, reset, and both together on a partly filled FIFO
    fill3();
    flush = 1'b1;
    #1;
    chk("flush_iready", 32'(a_in.ready), 32'd0);
    chk("flush_ovalid", 32'(a_out.valid), 32'd0);
    tick();
    flush = 1'b0;
    chk_cleared("flush");
    fill3();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_cleared("rst");
    fill3();
    rst   = 1'b1;
    flush = 1'b1;
    tick();
    rst   = 1'b0;
    flush = 1'b0;
    chk_cleared("rst_flush");

`ifdef DII_PACKET_FIFO_WATERMARK_EN
    // Watermark on DEPTH=8: fill to 6, drain, then flush
    flush_all();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(32'h40 + 32'(i));
      in_first = 1'b1;
      in_last  = 1'b1;
      tick();
    end
    idle_in();
    #1;
    chk("hw_fill", 32'(b_hw), 32'd6);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    #1;
    chk("hw_drained_level", 32'(b_level), 32'd0);
    chk("hw_drained", 32'(b_hw), 32'd6);
    flush_all();
    #1;
    chk("hw_flush", 32'(b_hw), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
